// File: rtl/tlp_host_emu.sv
// Host-side endpoint model: sinks FPGA->CPU memory-write TLPs into a host RAM port
// and acknowledges consumed chunks with rdPtr register-write TLPs.
module tlp_host_emu #(
  parameter int unsigned MEM_QW_BITS    = 12,
  parameter int unsigned NUMCHUNKS_BITS = 2,
  parameter logic [15:0] HOST_ID        = 16'h1CCC,
  parameter logic [31:0] RDPTR_ADDR     = 32'h00200018,
  parameter int unsigned ACK_DELAY      = 4
) (
  input  logic                      clk_in,
  input  logic                      reset_in,
  input  logic [63:0]               rxData_in,
  input  logic                      rxValid_in,
  output logic                      rxReady_out,
  input  logic                      rxSOP_in,
  input  logic                      rxEOP_in,
  output logic [63:0]               txData_out,
  output logic                      txValid_out,
  input  logic                      txReady_in,
  output logic                      txSOP_out,
  output logic                      txEOP_out,
  input  logic [28:0]               f2cBase_in,
  input  logic [28:0]               mtrBase_in,
  input  logic                      autoAck_in,
  output logic                      memWrEnable_out,
  output logic [MEM_QW_BITS-1:0]    memWrAddr_out,
  output logic [63:0]               memWrData_out,
  output logic [NUMCHUNKS_BITS-1:0] wrPtr_out,
  output logic [NUMCHUNKS_BITS-1:0] rdPtr_out,
  output logic [15:0]               tlpCount_out,
  output logic                      error_out
);

  localparam int unsigned DLY_W = (ACK_DELAY > 0) ? $clog2(ACK_DELAY + 1) : 1;
  localparam logic [63:0] ACK_HDR = {HOST_ID, 8'h00, 8'h0F, 8'h40, 14'd0, 10'd1};

  typedef enum logic [2:0] {R_IDLE, R_ADDR, R_DATA, R_MTR, R_DROP} rxState_t;
  typedef enum logic [1:0] {T_IDLE, T_WAIT, T_HDR, T_DATA} txState_t;

  rxState_t rxState, rxNext;
  txState_t txState, txNext;

  logic [8:0]             lenQw;
  logic [9:0]             beatCnt;
  logic [MEM_QW_BITS-1:0] wrAddr;
  logic [DLY_W-1:0]       dlyCnt;

  logic        rxBeat, hdrBad, inWin, lenMatch;
  logic [28:0] addrQw, qwOff;
  logic        loadHdr, loadOff, incBeat, capPtr, countTlp, setErr, ackDone;
  logic [NUMCHUNKS_BITS-1:0] rdPtrNext;

  assign rxBeat    = rxValid_in && rxReady_out;
  assign hdrBad    = (rxData_in[31:24] != 8'h40) || rxData_in[0] || (rxData_in[9:0] == 10'd0);
  assign addrQw    = rxData_in[31:3];
  assign qwOff     = addrQw - f2cBase_in;
  assign inWin     = (addrQw >= f2cBase_in) && ((qwOff >> MEM_QW_BITS) == 29'd0);
  assign lenMatch  = (beatCnt + 10'd1) == {1'b0, lenQw};
  assign rdPtrNext = rdPtr_out + NUMCHUNKS_BITS'(1);

  assign memWrAddr_out = wrAddr;
  assign memWrData_out = memWrEnable_out ? rxData_in : 64'd0;

  // State registers for both FSMs
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      rxState <= R_IDLE;
      txState <= T_IDLE;
    end else begin
      rxState <= rxNext;
      txState <= txNext;
    end
  end

  // RX decode; a SOP beat always restarts header parsing regardless of state
  always_comb begin
    rxNext          = rxState;
    loadHdr         = 1'b0;
    loadOff         = 1'b0;
    incBeat         = 1'b0;
    capPtr          = 1'b0;
    countTlp        = 1'b0;
    setErr          = 1'b0;
    memWrEnable_out = 1'b0;
    if (rxBeat) begin
      if (rxSOP_in) begin
        loadHdr = 1'b1;
        if (rxState != R_IDLE) setErr = 1'b1;
        if (hdrBad || rxEOP_in) begin
          setErr = 1'b1;
          rxNext = rxEOP_in ? R_IDLE : R_DROP;
        end else begin
          rxNext = R_ADDR;
        end
      end else begin
        case (rxState)
          R_IDLE: setErr = 1'b1;
          R_ADDR: begin
            if (rxEOP_in) begin
              setErr = 1'b1;
              rxNext = R_IDLE;
            end else if (rxData_in[2:0] != 3'd0) begin
              setErr = 1'b1;
              rxNext = R_DROP;
            end else if (addrQw == mtrBase_in) begin
              rxNext = R_MTR;
            end else if (inWin) begin
              loadOff = 1'b1;
              rxNext  = R_DATA;
            end else begin
              rxNext = R_DROP;
            end
          end
          R_DATA, R_MTR: begin
            incBeat         = 1'b1;
            memWrEnable_out = (rxState == R_DATA);
            capPtr          = (rxState == R_MTR) && (beatCnt == 10'd0);
            if (rxEOP_in) begin
              rxNext = R_IDLE;
              if (lenMatch) countTlp = 1'b1;
              else          setErr   = 1'b1;
            end
          end
          R_DROP: if (rxEOP_in) rxNext = R_IDLE;
          default: rxNext = R_IDLE;
        endcase
      end
    end
  end

  // RX datapath registers
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      rxReady_out  <= 1'b0;
      lenQw        <= '0;
      beatCnt      <= '0;
      wrAddr       <= '0;
      wrPtr_out    <= '0;
      tlpCount_out <= '0;
      error_out    <= 1'b0;
    end else begin
      rxReady_out <= 1'b1;
      if (loadHdr) begin
        lenQw   <= rxData_in[9:1];
        beatCnt <= '0;
      end else if (incBeat) begin
        beatCnt <= beatCnt + 10'd1;
      end
      if (loadOff)              wrAddr <= qwOff[MEM_QW_BITS-1:0];
      else if (memWrEnable_out) wrAddr <= wrAddr + MEM_QW_BITS'(1);
      if (capPtr)   wrPtr_out    <= rxData_in[NUMCHUNKS_BITS-1:0];
      if (countTlp) tlpCount_out <= tlpCount_out + 16'd1;
      if (setErr)   error_out    <= 1'b1;
    end
  end

  // TX ack sequencer; ack requests are only re-evaluated from T_IDLE
  always_comb begin
    txNext  = txState;
    ackDone = 1'b0;
    case (txState)
      T_IDLE: if (autoAck_in && (wrPtr_out != rdPtr_out)) txNext = T_WAIT;
      T_WAIT: if (dlyCnt == '0) txNext = T_HDR;
      T_HDR:  if (txReady_in) txNext = T_DATA;
      T_DATA: begin
        if (txReady_in) begin
          txNext  = T_IDLE;
          ackDone = 1'b1;
        end
      end
      default: txNext = T_IDLE;
    endcase
  end

  // TX outputs registered from next state so beats hold steady under backpressure
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      dlyCnt      <= '0;
      rdPtr_out   <= '0;
      txValid_out <= 1'b0;
      txSOP_out   <= 1'b0;
      txEOP_out   <= 1'b0;
      txData_out  <= '0;
    end else begin
      if (txState == T_IDLE)                       dlyCnt <= DLY_W'(ACK_DELAY);
      else if (txState == T_WAIT && dlyCnt != '0)  dlyCnt <= dlyCnt - DLY_W'(1);
      if (ackDone) rdPtr_out <= rdPtrNext;
      txValid_out <= (txNext == T_HDR) || (txNext == T_DATA);
      txSOP_out   <= (txNext == T_HDR);
      txEOP_out   <= (txNext == T_DATA);
      if (txNext == T_HDR)       txData_out <= ACK_HDR;
      else if (txNext == T_DATA) txData_out <= {32'(rdPtrNext), RDPTR_ADDR};
      else                       txData_out <= '0;
    end
  end

endmodule

// File: tb/tb_tlp_host_emu.sv
// Directed/randomized bench for tlp_host_emu against a transaction-level model
// of host memory writes, pointer capture, error flag and ack TLPs.
module tb_tlp_host_emu;

  localparam logic [31:0] RDPTR   = 32'h00200018;
  localparam logic [63:0] ACK_HDR = 64'h1CCC_000F_4000_0001;

  logic        clk_in, reset_in;
  logic [63:0] rxData_in;
  logic        rxValid_in, rxReady_out, rxSOP_in, rxEOP_in;
  logic [63:0] txData_out;
  logic        txValid_out, txReady_in, txSOP_out, txEOP_out;
  logic [28:0] f2cBase, mtrBase;
  logic        autoAck_in;
  logic        memWrEnable_out;
  logic [11:0] memWrAddr_out;
  logic [63:0] memWrData_out;
  logic [1:0]  wrPtr_out, rdPtr_out;
  logic [15:0] tlpCount_out;
  logic        error_out;

  tlp_host_emu #(
    .MEM_QW_BITS(12), .NUMCHUNKS_BITS(2), .HOST_ID(16'h1CCC),
    .RDPTR_ADDR(RDPTR), .ACK_DELAY(4)
  ) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .rxData_in(rxData_in), .rxValid_in(rxValid_in), .rxReady_out(rxReady_out),
    .rxSOP_in(rxSOP_in), .rxEOP_in(rxEOP_in),
    .txData_out(txData_out), .txValid_out(txValid_out), .txReady_in(txReady_in),
    .txSOP_out(txSOP_out), .txEOP_out(txEOP_out),
    .f2cBase_in(f2cBase), .mtrBase_in(mtrBase), .autoAck_in(autoAck_in),
    .memWrEnable_out(memWrEnable_out), .memWrAddr_out(memWrAddr_out),
    .memWrData_out(memWrData_out), .wrPtr_out(wrPtr_out), .rdPtr_out(rdPtr_out),
    .tlpCount_out(tlpCount_out), .error_out(error_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int          nCmp  = 0;
  int          nFail = 0;
  bit          expErr;
  logic [15:0] expCount;
  logic [1:0]  expWrPtr;

  logic [11:0] wrAddrQ[$];
  logic [63:0] wrDataQ[$];
  logic [65:0] txQ[$];

  // Record every host-memory write and every accepted TX beat
  always @(negedge clk_in) begin
    if (memWrEnable_out) begin
      wrAddrQ.push_back(memWrAddr_out);
      wrDataQ.push_back(memWrData_out);
    end
    if (txValid_out && txReady_in) txQ.push_back({txSOP_out, txEOP_out, txData_out});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic sendBeat(input logic [63:0] d, input logic s, input logic e);
    rxData_in  = d;
    rxValid_in = 1'b1;
    rxSOP_in   = s;
    rxEOP_in   = e;
    tick();
    rxValid_in = 1'b0;
    rxSOP_in   = 1'b0;
    rxEOP_in   = 1'b0;
  endtask

  function automatic logic [31:0] qwAddr(input longint qw);
    return 32'(qw * 8);
  endfunction

  // payMode: 0 random, 1 sequential pattern, 2 random with forced first QW
  task automatic runTlp(input string tag, input logic [7:0] fmt, input int lenDw,
                        input logic [31:0] addr, input int nPay, input int payMode,
                        input logic [63:0] firstQw);
    logic [63:0] pay[$];
    logic [11:0] eA[$];
    logic [63:0] eD[$];
    longint q, fb;
    int n;
    for (int i = 0; i < nPay; i++) begin
      if (payMode == 1) pay.push_back({32'(i), 32'hA5A50000 + 32'(i)});
      else              pay.push_back({$urandom, $urandom});
    end
    if (payMode == 2) pay[0] = firstQw;
    q  = longint'(addr >> 3);
    fb = longint'(f2cBase);
    if (fmt != 8'h40 || (lenDw % 2) != 0 || lenDw == 0) begin
      expErr = 1'b1;
    end else if (addr[2:0] != 3'd0) begin
      expErr = 1'b1;
    end else if (q == longint'(mtrBase)) begin
      expWrPtr = pay[0][1:0];
      if (nPay == lenDw / 2) expCount = expCount + 16'd1;
      else                   expErr   = 1'b1;
    end else if (q >= fb && q < fb + 4096) begin
      for (int i = 0; i < nPay; i++) begin
        eA.push_back(12'((q - fb + i) % 4096));
        eD.push_back(pay[i]);
      end
      if (nPay == lenDw / 2) expCount = expCount + 16'd1;
      else                   expErr   = 1'b1;
    end
    wrAddrQ.delete();
    wrDataQ.delete();
    sendBeat({16'hABCD, 8'($urandom), 8'hFF, fmt, 14'd0, 10'(lenDw)}, 1'b1, 1'b0);
    sendBeat({32'h0BADF00D, addr}, 1'b0, 1'b0);
    for (int i = 0; i < nPay; i++) sendBeat(pay[i], 1'b0, i == nPay - 1);
    repeat (3) tick();
    @(negedge clk_in);
    chk({tag, "_nwr"}, 128'(wrAddrQ.size()), 128'(eA.size()));
    n = (wrAddrQ.size() < eA.size()) ? wrAddrQ.size() : eA.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 128'(wrAddrQ[i]), 128'(eA[i]));
      chk($sformatf("%s_data%0d", tag, i), 128'(wrDataQ[i]), 128'(eD[i]));
    end
    chk({tag, "_err"},   128'(error_out),    128'(expErr));
    chk({tag, "_count"}, 128'(tlpCount_out), 128'(expCount));
    chk({tag, "_wrptr"}, 128'(wrPtr_out),    128'(expWrPtr));
    tick();
  endtask

  task automatic waitRdPtr(input logic [1:0] v, input int budget);
    int k = 0;
    while (rdPtr_out !== v && k < budget) begin
      tick();
      k++;
    end
    chk("wait_rdptr", 128'(rdPtr_out), 128'(v));
  endtask

  task automatic waitTxValid(input int budget);
    int k = 0;
    while (txValid_out !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    chk("wait_txvalid", 128'(txValid_out), 128'(1'b1));
  endtask

  initial begin
    int off, n;
    rxData_in  = '0;
    rxValid_in = 1'b0;
    rxSOP_in   = 1'b0;
    rxEOP_in   = 1'b0;
    txReady_in = 1'b1;
    autoAck_in = 1'b1;
    f2cBase    = 29'h1BADCAFE;
    mtrBase    = 29'h00400000;
    reset_in   = 1'b0;
    expErr     = 1'b0;
    expCount   = '0;
    expWrPtr   = '0;

    repeat (3) tick();
    @(negedge clk_in);
    chk("rst_rxready", 128'(rxReady_out), 128'(0));
    chk("rst_txvalid", 128'(txValid_out), 128'(0));
    chk("rst_count",   128'(tlpCount_out), 128'(0));
    chk("rst_err",     128'(error_out), 128'(0));
    chk("rst_ptrs",    128'({wrPtr_out, rdPtr_out}), 128'(0));
    chk("rst_memwr",   128'(memWrEnable_out), 128'(0));
    tick();
    reset_in = 1'b1;
    tick();
    @(negedge clk_in);
    chk("rxready_up", 128'(rxReady_out), 128'(1));
    tick();

    // 128-byte write at QW offset 16
    runTlp("f2c_seq", 8'h40, 32, qwAddr(longint'(f2cBase) + 16), 16, 1, '0);

    // Metrics write of wrPtr=2 triggers two acks
    txQ.delete();
    runTlp("mtr2", 8'h40, 4, qwAddr(longint'(mtrBase)), 2, 2, 64'hFFFF000000000002);
    waitRdPtr(2'd2, 200);
    repeat (2) tick();
    @(negedge clk_in);
    chk("ack2_nbeats", 128'(txQ.size()), 128'(4));
    if (txQ.size() == 4) begin
      chk("ack2_b0", 128'(txQ[0]), 128'({2'b10, ACK_HDR}));
      chk("ack2_b1", 128'(txQ[1]), 128'({2'b01, 32'd1, RDPTR}));
      chk("ack2_b2", 128'(txQ[2]), 128'({2'b10, ACK_HDR}));
      chk("ack2_b3", 128'(txQ[3]), 128'({2'b01, 32'd2, RDPTR}));
    end
    tick();

    // Header beat must hold under backpressure
    txReady_in = 1'b0;
    txQ.delete();
    runTlp("mtr3", 8'h40, 4, qwAddr(longint'(mtrBase)), 2, 2, 64'h0000000000000007);
    waitTxValid(100);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      chk($sformatf("bp_valid%0d", i), 128'(txValid_out), 128'(1));
      chk($sformatf("bp_sop%0d", i),   128'(txSOP_out),   128'(1));
      chk($sformatf("bp_data%0d", i),  128'(txData_out),  128'(ACK_HDR));
      tick();
    end
    txReady_in = 1'b1;
    waitRdPtr(2'd3, 50);
    repeat (2) tick();
    @(negedge clk_in);
    chk("bp_nbeats", 128'(txQ.size()), 128'(2));
    if (txQ.size() == 2) begin
      chk("bp_b0", 128'(txQ[0]), 128'({2'b10, ACK_HDR}));
      chk("bp_b1", 128'(txQ[1]), 128'({2'b01, 32'd3, RDPTR}));
    end
    tick();

    // Windows and boundaries
    runTlp("drop_above", 8'h40, 8, qwAddr(longint'(f2cBase) + 4096), 4, 0, '0);
    runTlp("drop_below", 8'h40, 8, qwAddr(longint'(f2cBase) - 1), 4, 0, '0);
    runTlp("wrap_end",   8'h40, 8, qwAddr(longint'(f2cBase) + 4094), 4, 0, '0);
    for (int i = 0; i < 6; i++) begin
      off = int'($urandom_range(0, 4095));
      n   = int'($urandom_range(1, 12));
      runTlp($sformatf("rnd%0d", i), 8'h40, 2 * n, qwAddr(longint'(f2cBase) + off), n, 0, '0);
    end

    // Protocol errors; error flag stays set afterwards
    runTlp("unaligned", 8'h40, 8, qwAddr(longint'(f2cBase) + 10) + 32'd4, 4, 0, '0);
    runTlp("bad_fmt",   8'h00, 8, qwAddr(longint'(f2cBase) + 20), 4, 0, '0);
    runTlp("short_eop", 8'h40, 32, qwAddr(longint'(f2cBase) + 40), 8, 0, '0);
    runTlp("after_err", 8'h40, 8, qwAddr(longint'(f2cBase) + 100), 4, 0, '0);
    for (int i = 0; i < 3; i++) begin
      off = int'($urandom_range(0, 4095));
      n   = int'($urandom_range(1, 8));
      runTlp($sformatf("rnd_late%0d", i), 8'h40, 2 * n, qwAddr(longint'(f2cBase) + off), n, 0, '0);
    end

    // Reset while an ack header is being offered
    txReady_in = 1'b0;
    runTlp("mtr0", 8'h40, 4, qwAddr(longint'(mtrBase)), 2, 2, 64'h0000000000000000);
    waitTxValid(100);
    reset_in = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    chk("rst2_txvalid", 128'(txValid_out), 128'(0));
    chk("rst2_txflags", 128'({txSOP_out, txEOP_out}), 128'(0));
    chk("rst2_txdata",  128'(txData_out), 128'(0));
    chk("rst2_ptrs",    128'({wrPtr_out, rdPtr_out}), 128'(0));
    chk("rst2_count",   128'(tlpCount_out), 128'(0));
    chk("rst2_err",     128'(error_out), 128'(0));
    chk("rst2_rxready", 128'(rxReady_out), 128'(0));
    tick();
    reset_in   = 1'b1;
    txReady_in = 1'b1;
    repeat (2) tick();
    @(negedge clk_in);
    chk("rst2_rxready_up", 128'(rxReady_out), 128'(1));
    chk("rst2_idle_tx",    128'(txValid_out), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
